mux4x1_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one MUX4X1_4bits among four 4-bit requesters, e.g. the game FSM, the sequence player, the score display and the input echo.
- Drives the mux `sel` and a one-hot `grant` back to the requesters.
- Holds a grant until the owner releases it. When the timeout feature is compiled in, a grant is also force-released after MAX_HOLD cycles.
- Sits between the requesting blocks and the shared 4-bit LED/display mux.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_picker_4.sv | 27 ++
 rtl/mux4x1_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux4x1_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and grant helper for the round-robin mux arbiter
package mux_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [N_REQ-1:0] sel_to_grant(input logic [SEL_W-1:0] s);
        return N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_picker_4.sv
// rtl/rr_picker_4.sv - combinational rotating priority encoder, first set bit after 'last' wins
module rr_picker_4
    import mux_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] w_cand;

    // Scan from the farthest candidate to the nearest so the nearest set bit overwrites the rest.
    always_comb begin
        idx    = 2'd0;
        found  = 1'b0;
        w_cand = 2'd0;
        for (int d = N_REQ; d >= 1; d--) begin
            w_cand = last + SEL_W'(d);
            if (req[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// rtl/mux4x1_rr_arbiter.sv - round-robin owner of the shared 4-bit mux; ARB_TIMEOUT_EN adds forced release
module mux4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 31 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
        $error("mux4x1_rr_arbiter: MAX_HOLD/CNT_W out of range");
    end

    arb_state_t r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_sel,   w_sel_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic       r_busy,  w_busy_nxt;
    logic [1:0] w_idx;
    logic       w_found;

    rr_picker_4 u_picker (
        .req   (req),
        .last  (r_last),
        .idx   (w_idx),
        .found (w_found)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic             r_timeout,  w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_grant_nxt = sel_to_grant(w_idx);
                    w_sel_nxt   = w_idx;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = r_sel;
                    w_state_nxt = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                // A saturated owner keeps the mux until someone else actually asks for it.
                else if (r_hold_cnt == HOLD_LAST) begin
                    if ((req & ~r_grant) != 4'b0000) begin
                        w_grant_nxt   = 4'b0000;
                        w_busy_nxt    = 1'b0;
                        w_last_nxt    = r_sel;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// tb/tb_mux4x1_rr_arbiter.sv - directed and random checks of the arbiter against an owner/last model
module tb_mux4x1_rr_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    mux4x1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    // Model: owner index (-1 = nobody), last released owner, cycles held, pulse flag.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        bit picked;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 3;
            m_sel   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                picked = 1'b0;
                for (int d = 1; d <= 4; d++) begin
                    if (!picked && req[(m_last + d) % 4]) begin
                        m_owner = (m_last + d) % 4;
                        m_sel   = m_owner;
                        m_hold  = 0;
                        picked  = 1'b1;
                    end
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_hold == MAX_HOLD - 1) begin
                    if ((req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                        m_last  = m_owner;
                        m_owner = -1;
                        m_to    = 1'b1;
                    end
                end else begin
                    m_hold = m_hold + 1;
                end
`endif
            end
        end
    end

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model grant", 32'(grant), 32'(exp_grant()));
            chk("model sel", 32'(sel), 32'(m_sel));
            chk("model busy", 32'(busy), 32'(m_owner >= 0));
            chk("model timeout", 32'(timeout), 32'(m_to));
        end
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'b0000);
        rst_n = 1'b1;
    endtask

    logic [3:0] r_rand;
    int         e;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset sel", 32'(sel), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        step(4'b0101);
        chk("t1 first grant", 32'(grant), 32'h1);
        chk("t1 first sel", 32'(sel), 32'h0);
        step(4'b0100);
        chk("t1 dead grant", 32'(grant), 32'h0);
        chk("t1 dead sel", 32'(sel), 32'h0);
        step(4'b0100);
        chk("t1 second grant", 32'(grant), 32'h4);
        chk("t1 second sel", 32'(sel), 32'h2);
        step(4'b0000);

        do_reset();
        req = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            e = i % 4;
            chk("t2 owner", 32'(grant), 32'(4'b0001 << e));
            repeat (2) @(negedge clk);
            step(4'hF & ~(4'b0001 << e));
            chk("t2 dead", 32'(grant), 32'h0);
            step(4'hF);
        end
        step(4'b0000);

        step(4'b1000);
        chk("t3 wrap grant", 32'(grant), 32'h8);
        chk("t3 wrap sel", 32'(sel), 32'h3);
        step(4'b0000);
        step(4'b1001);
        chk("t3 after wrap grant", 32'(grant), 32'h1);
        chk("t3 after wrap sel", 32'(sel), 32'h0);
        step(4'b0000);

        step(4'b0010);
        chk("t4 pre-reset grant", 32'(grant), 32'h2);
        rst_n = 1'b0;
        step(4'b0010);
        chk("t4 reset grant", 32'(grant), 32'h0);
        chk("t4 reset sel", 32'(sel), 32'h0);
        chk("t4 reset busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step(4'b0010);
        chk("t4 regrant", 32'(grant), 32'h2);
        step(4'b0000);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        step(4'b0010);
        chk("t5 grant cycle 1", 32'(grant), 32'h2);
        repeat (4) @(negedge clk);
        req = 4'b0110;
        repeat (11) @(negedge clk);
        chk("t5 grant cycle 16", 32'(grant), 32'h2);
        chk("t5 no early pulse", 32'(timeout), 32'h0);
        @(negedge clk);
        chk("t5 timeout pulse", 32'(timeout), 32'h1);
        chk("t5 forced dead", 32'(grant), 32'h0);
        @(negedge clk);
        chk("t5 next owner", 32'(grant), 32'h4);
        chk("t5 pulse one cycle", 32'(timeout), 32'h0);
        step(4'b0000);

        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t6 lone grant", 32'(grant), 32'h1);
            chk("t6 lone timeout", 32'(timeout), 32'h0);
        end
        step(4'b0000);
`endif

        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                r_rand = req;
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, (ph == 0) ? 3 : 31) == 0) r_rand[b] = ~r_rand[b];
                end
                rst_n = ($urandom_range(0, 199) != 0);
                step(r_rand);
            end
        end
        rst_n = 1'b1;
        step(4'b0000);
        step(4'b0000);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
